// File: rtl/wb_write_scheduler_if.sv
// Writeback request / register-file write bundle shared by the scheduler and its sender.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; the sender holds
// icode/rA/rB/valE/valM/Cnd stable while req_valid is high and the request has not transferred.
interface wb_write_scheduler_if #(
    parameter int DATA_W = 64
) ();
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic              Cnd;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [14:0]       pend_mask;
    logic              idle;

    modport slave (
        input  req_valid, icode, rA, rB, valE, valM, Cnd,
        output req_ready, wr_en, wr_addr, wr_data, pend_mask, idle
    );

    modport master (
        output req_valid, icode, rA, rB, valE, valM, Cnd,
        input  req_ready, wr_en, wr_addr, wr_data, pend_mask, idle
    );
endinterface

// File: rtl/wb_write_scheduler.sv
// Queues writeback requests, decodes them into dstE/dstM writes and serialises them onto a
// single register-file write port; publishes a pending-write mask for hazard detection.
module wb_write_scheduler #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    wb_write_scheduler_if.slave bus,
    output logic                dbg_phase
);
    localparam int         PW   = $clog2(DEPTH);
    localparam int         CW   = PW + 1;
    localparam logic [3:0] NONE = 4'hF;

    typedef enum logic {PH_E = 1'b0, PH_M = 1'b1} phase_t;

    phase_t            phase, phase_next;
    logic [3:0]        q_dst_e [DEPTH];
    logic [3:0]        q_dst_m [DEPTH];
    logic [DATA_W-1:0] q_val_e [DEPTH];
    logic [DATA_W-1:0] q_val_m [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;

    logic              wr_en_q;
    logic [3:0]        wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [3:0]        dec_e, dec_m;
    logic              push, pop, issue;
    logic [3:0]        issue_addr;
    logic [DATA_W-1:0] issue_data;
    logic [14:0]       pend;
    logic [PW-1:0]     offs;

    function automatic logic [14:0] onehot(input logic [3:0] id);
        // id 15 shifts into bit 15, which the cast drops: "no register" contributes nothing
        onehot = 15'(16'd1 << id);
    endfunction

    always_comb begin
        dec_e = NONE;
        dec_m = NONE;
        case (bus.icode)
            4'd2:              dec_e = bus.Cnd ? bus.rB : NONE;
            4'd3, 4'd6:        dec_e = bus.rB;
            4'd5:              dec_m = bus.rA;
            4'd8, 4'd9, 4'd10: dec_e = 4'd4;
            4'd11: begin
                dec_e = 4'd4;
                dec_m = bus.rA;
            end
            default: ;
        endcase
    end

    // Requests with no destination complete the handshake but never occupy a slot.
    assign bus.req_ready = rst_n && (count < CW'(DEPTH));
    assign push = bus.req_valid && bus.req_ready && ((dec_e != NONE) || (dec_m != NONE));

    always_comb begin
        phase_next = phase;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_addr = q_dst_e[rd_ptr];
        issue_data = q_val_e[rd_ptr];
        if (count != '0) begin
            if ((phase == PH_E) && (q_dst_e[rd_ptr] != NONE)) begin
                issue = 1'b1;
                if (q_dst_m[rd_ptr] == NONE) begin
                    pop = 1'b1;
                end else begin
                    phase_next = PH_M;
                end
            end else begin
                if (q_dst_m[rd_ptr] != NONE) begin
                    issue      = 1'b1;
                    issue_addr = q_dst_m[rd_ptr];
                    issue_data = q_val_m[rd_ptr];
                end
                pop        = 1'b1;
                phase_next = PH_E;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PH_E;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            phase   <= phase_next;
            wr_en_q <= issue;
            if (issue) begin
                wr_addr_q <= issue_addr;
                wr_data_q <= issue_data;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_dst_e[wr_ptr] <= dec_e;
            q_dst_m[wr_ptr] <= dec_m;
            q_val_e[wr_ptr] <= bus.valE;
            q_val_m[wr_ptr] <= bus.valM;
        end
    end

    // The head's E destination drops out of the mask once its E write has been presented.
    always_comb begin
        pend = '0;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ({1'b0, offs} < count) begin
                if (!((offs == '0) && (phase == PH_M))) pend = pend | onehot(q_dst_e[i]);
                pend = pend | onehot(q_dst_m[i]);
            end
        end
        if (wr_en_q) pend = pend | onehot(wr_addr_q);
    end

    assign bus.pend_mask = pend;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.idle      = (count == '0) && !wr_en_q;
    assign dbg_phase     = (phase == PH_M);
endmodule
